// File: rtl/regfile_pkg.sv
// Purpose: shared defaults and dump FSM encoding for the parametrised register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREGS  = 32;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Purpose: debug dump sequencer; walks register indices 0..NREGS-1 and holds each word.
// Latency: first word valid one cycle after dump_start; then one word per accepted handshake.
// Backpressure: the held word (data/addr/last) stays frozen while o_valid=1 and i_ready=0.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_rd_val,
    output logic [ADDR_W-1:0] o_rd_idx,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic [ADDR_W-1:0] w_next_idx;
    logic              w_hs;

    assign w_next_idx = r_idx + 1'b1;
    assign w_hs       = r_valid & i_ready;

    // Index the top level must read this cycle: 0 when starting, else the next word.
    always_comb begin
        o_rd_idx = '0;
        if (r_state == DUMP_SEND) begin
            o_rd_idx = w_next_idx;
        end
    end

    // Dump FSM: capture a word on start or on each accepted handshake, stop after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DUMP_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                DUMP_IDLE: begin
                    if (i_start) begin
                        r_idx   <= '0;
                        r_data  <= i_rd_val;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_state <= DUMP_SEND;
                    end
                end
                DUMP_SEND: begin
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= DUMP_IDLE;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_data <= i_rd_val;
                            r_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= DUMP_IDLE;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_idx;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_busy  = r_busy;

endmodule

// File: rtl/regfile_param.sv
// Purpose: 2-read/1-write register file with write bypass, stall hold and a debug dump stream.
// Latency: reads registered, 1 cycle; dump words one per cycle when the consumer is always ready.
// Backpressure: dump stream stalls on i_dump_ready=0; pipeline reads/writes are never blocked.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NREGS    = RF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_dump_start,
    input  logic              i_dump_ready,
    output logic              o_dump_valid,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_dump_last,
    output logic              o_dump_busy
);

    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;

    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_dump_idx;
    logic [DATA_W-1:0] w_rval1;
    logic [DATA_W-1:0] w_rval2;
    logic [DATA_W-1:0] w_dval;

    // Address is backed by real storage (in range and not the hard-wired zero register).
    function automatic logic f_addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Architectural read value including same-cycle forwarding of an accepted write.
    function automatic logic [DATA_W-1:0] f_value(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              wr_ok,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (f_addr_ok(a)) begin
            if ((BYPASS != 0) && wr_ok && (wa == a)) begin
                v = wd;
            end else begin
                v = stored;
            end
        end
        return v;
    endfunction

    assign w_wr_ok = i_we && f_addr_ok(i_waddr);

    // Three independent read muxes: two pipeline ports and the dump engine.
    always_comb begin
        w_rval1 = f_value(i_raddr1, r_regs[i_raddr1], w_wr_ok, i_waddr, i_wdata);
        w_rval2 = f_value(i_raddr2, r_regs[i_raddr2], w_wr_ok, i_waddr, i_wdata);
        w_dval  = f_value(w_dump_idx, r_regs[w_dump_idx], w_wr_ok, i_waddr, i_wdata);
    end

    // Storage array; dropped writes (out of range or zero register) leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Registered read ports, frozen while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (!i_stall) begin
            r_rdata1 <= w_rval1;
            r_rdata2 <= w_rval2;
        end
    end

    assign o_rdata1 = r_rdata1;
    assign o_rdata2 = r_rdata2;

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dump (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_dump_start),
        .i_ready  (i_dump_ready),
        .i_rd_val (w_dval),
        .o_rd_idx (w_dump_idx),
        .o_valid  (o_dump_valid),
        .o_addr   (o_dump_addr),
        .o_data   (o_dump_data),
        .o_last   (o_dump_last),
        .o_busy   (o_dump_busy)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Purpose: directed + random check of regfile_param against a behavioural model.
// Latency: model predicts registered reads and dump words one cycle after each edge.
// Backpressure: dump consumer readiness is driven by the bench.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic        stall = 1'b0;
    logic        dump_start = 1'b0;
    logic        dump_ready = 1'b0;

    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic        dump_valid, dump_last, dump_busy;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        nb_dump_valid, nb_dump_last, nb_dump_busy;
    logic [4:0]  nb_dump_addr;
    logic [31:0] nb_dump_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .i_stall(stall),
        .o_rdata1(rdata1), .o_rdata2(rdata2),
        .i_dump_start(dump_start), .i_dump_ready(dump_ready),
        .o_dump_valid(dump_valid), .o_dump_addr(dump_addr), .o_dump_data(dump_data),
        .o_dump_last(dump_last), .o_dump_busy(dump_busy)
    );

    // Second instance: no bypass and only 24 registers, sharing all inputs.
    regfile_param #(.NREGS(24), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .i_stall(stall),
        .o_rdata1(nb_rdata1), .o_rdata2(nb_rdata2),
        .i_dump_start(1'b0), .i_dump_ready(1'b1),
        .o_dump_valid(nb_dump_valid), .o_dump_addr(nb_dump_addr), .o_dump_data(nb_dump_data),
        .o_dump_last(nb_dump_last), .o_dump_busy(nb_dump_busy)
    );

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] exp_rd1, exp_rd2, exp_nb1, exp_nb2;
    bit          m_busy, m_valid, m_last;
    int          m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] val(int a, bit byp, int nregs);
        if (a == 0 || a >= nregs) return 32'h0;
        if (byp && we && int'(waddr) == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_rd1 = '0; exp_rd2 = '0; exp_nb1 = '0; exp_nb2 = '0;
        m_busy = 0; m_valid = 0; m_last = 0; m_addr = 0; m_data = '0;
    endtask

    // Advance one clock: predict every output from the pre-edge state, then commit.
    task automatic tick();
        logic [31:0] n1, n2, nn1, nn2, nd;
        n1  = val(int'(raddr1), 1'b1, 32);
        n2  = val(int'(raddr2), 1'b1, 32);
        nn1 = val(int'(raddr1), 1'b0, 24);
        nn2 = val(int'(raddr2), 1'b0, 24);
        if (!stall) begin
            exp_rd1 = n1; exp_rd2 = n2; exp_nb1 = nn1; exp_nb2 = nn2;
        end
        if (!m_busy) begin
            if (dump_start) begin
                m_busy = 1; m_valid = 1; m_addr = 0; m_data = val(0, 1'b1, 32); m_last = 0;
            end
        end else if (m_valid && dump_ready) begin
            if (m_addr == 31) begin
                m_valid = 0; m_busy = 0; m_last = 0;
            end else begin
                nd = val(m_addr + 1, 1'b1, 32);
                m_addr = m_addr + 1; m_data = nd; m_last = (m_addr == 31);
            end
        end
        if (we && waddr != 5'd0) m_regs[waddr] = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reads(string tag);
        chk({tag, "_rd1"}, rdata1, exp_rd1);
        chk({tag, "_rd2"}, rdata2, exp_rd2);
    endtask

    task automatic chk_dump(string tag);
        chk({tag, "_valid"}, 32'(dump_valid), 32'(m_valid));
        chk({tag, "_busy"}, 32'(dump_busy), 32'(m_busy));
        chk({tag, "_last"}, 32'(dump_last), 32'(m_last));
        if (m_valid) begin
            chk({tag, "_addr"}, 32'(dump_addr), 32'(m_addr));
            chk({tag, "_data"}, dump_data, m_data);
        end
    endtask

    // Asynchronous reset pulse, checked while still asserted (no clock edge involved).
    task automatic pulse_reset(string tag);
        rst = 1'b1;
        #1;
        model_clear();
        chk({tag, "_rd1"}, rdata1, 32'h0);
        chk({tag, "_rd2"}, rdata2, 32'h0);
        chk({tag, "_valid"}, 32'(dump_valid), 32'h0);
        chk({tag, "_busy"}, 32'(dump_busy), 32'h0);
        chk({tag, "_last"}, 32'(dump_last), 32'h0);
        chk({tag, "_addr"}, 32'(dump_addr), 32'h0);
        chk({tag, "_data"}, dump_data, 32'h0);
        #1;
        rst = 1'b0;
    endtask

    task automatic write(int a, logic [31:0] d);
        we = 1'b1; waddr = 5'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int words, lasts, c;
        bit wrote4, reached10;
        model_clear();

        // Reset state
        pulse_reset("reset");
        raddr1 = 5'd3; raddr2 = 5'd0;
        tick();
        chk_reads("after_reset");
        chk("after_reset_rd1_const", rdata1, 32'h0);
        chk_dump("after_reset_dump");

        // Plain write then read
        write(5, 32'hDEADBEEF);
        raddr1 = 5'd5;
        tick();
        chk_reads("wr5");
        chk("wr5_const", rdata1, 32'hDEADBEEF);

        // Same-cycle write/read: bypass vs pre-write value
        write(7, 32'h0000_0099);
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234; raddr1 = 5'd7;
        tick();
        we = 1'b0;
        chk("byp_rd1", rdata1, 32'h1234);
        chk("nobyp_rd1", nb_rdata1, 32'h0000_0099);

        // Zero register ignores writes, including the bypass path
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        we = 1'b0;
        chk("zero_byp", rdata1, 32'h0);
        tick();
        chk("zero_read", rdata1, 32'h0);
        chk_reads("zero");

        // Stall hold
        write(1, 32'hA1); write(2, 32'hA2); write(3, 32'hA3);
        raddr1 = 5'd5;
        tick();
        stall = 1'b1;
        for (int a = 1; a <= 3; a++) begin
            raddr1 = 5'(a);
            tick();
            chk("stall_hold", rdata1, 32'hDEADBEEF);
            chk_reads("stall");
        end
        stall = 1'b0;
        tick();
        chk("stall_release", rdata1, 32'hA3);

        // Random traffic on both instances, including out-of-range reads for the 24-entry one
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = 5'($urandom_range(0, 31));
            stall = ($urandom_range(0, 3) == 0);
            tick();
            chk_reads("rand");
            chk("rand_nb_rd1", nb_rdata1, exp_nb1);
            chk("rand_nb_rd2", nb_rdata2, exp_nb2);
        end
        we = 1'b0; stall = 1'b0;

        // Full dump, consumer always ready
        for (int i = 0; i < 32; i++) write(i, 32'(i * 32'h11));
        dump_ready = 1'b1; dump_start = 1'b1;
        words = 0; lasts = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            dump_start = (i == 5);
            if (dump_valid) begin
                words++;
                chk("dump_data_const", dump_data, 32'(dump_addr) * 32'h11);
            end
            if (dump_last) begin
                lasts++;
                chk("dump_last_addr", 32'(dump_addr), 32'd31);
            end
            chk_dump("dump_full");
        end
        dump_start = 1'b0;
        chk("dump_word_count", 32'(words), 32'd32);
        chk("dump_last_count", 32'(lasts), 32'd1);

        // Throttled dump with a write under the held word 4 and a reset at word 10
        dump_ready = 1'b0; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk_dump("thr_start");
        wrote4 = 0; reached10 = 0;
        for (c = 0; c < 200 && !reached10; c++) begin
            dump_ready = (c % 3 == 0);
            we = 1'b0;
            if (m_valid && m_addr == 4 && !dump_ready && !wrote4) begin
                we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_0004; wrote4 = 1;
            end
            dump_start = 1'($urandom_range(0, 1));
            tick();
            chk_dump("thr");
            if (m_valid && m_addr == 4) chk("thr_word4_captured", dump_data, 32'h44);
            if (m_valid && m_addr == 10) begin
                reached10 = 1;
                pulse_reset("mid_reset");
            end
        end
        we = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        chk("thr_reached_word10", 32'(reached10), 32'd1);
        chk("thr_word4_written", 32'(wrote4), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_dump("post_abort");
            chk("post_abort_valid", 32'(dump_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
